// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM states and latency classes for the ALU sequencer.
package alu_seq_pkg;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    typedef enum logic [1:0] {LAT_SIMPLE, LAT_MUL, LAT_DIV} lat_e;
endpackage

// File: rtl/alu_sequencer_if.sv
// Request/ALU/response bundle; slave is the sequencer side, master the requester/ALU side.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_z;
    logic        res_err;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, alu_c, res_ready,
        output req_ready, alu_a, alu_b, alu_opcode, res_valid, res_z, res_err,
               hi_out, lo_out, busy
    );
    modport master (
        output req_valid, req_opcode, req_a, req_b, alu_c, res_ready,
        input  req_ready, alu_a, alu_b, alu_opcode, res_valid, res_z, res_err,
               hi_out, lo_out, busy
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, latency class, HI/LO write, divide-by-zero.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0]  opcode_i,
    input  logic [31:0] b_i,
    output logic        legal_o,
    output lat_e        lat_o,
    output logic        writes_hilo_o,
    output logic        div_zero_o
);
    always_comb begin
        legal_o       = 1'b1;
        lat_o         = LAT_SIMPLE;
        writes_hilo_o = 1'b0;
        unique case (opcode_i)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_NEG, OP_NOT: ;
            OP_MUL: begin lat_o = LAT_MUL; writes_hilo_o = 1'b1; end
            OP_DIV: begin lat_o = LAT_DIV; writes_hilo_o = 1'b1; end
            default: legal_o = 1'b0;
        endcase
    end

    assign div_zero_o = (opcode_i == OP_DIV) && (b_i == 32'd0);
endmodule

// File: rtl/alu_sequencer.sv
// One-at-a-time ALU front end: latch operands, wait per-class latency, capture result and HI/LO.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic          clk,
    input  logic          clear,
    alu_sequencer_if.slave bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   alu_a_q, alu_b_q, hi_q, lo_q;
    logic [4:0]    alu_op_q;
    logic [63:0]   res_z_q;
    logic          res_err_q, res_valid_q, busy_q, err_q, hilo_q;

    logic legal, writes_hilo, div_zero, err_d;
    lat_e lat;

    alu_op_decode u_dec (
        .opcode_i     (bus.req_opcode),
        .b_i          (bus.req_b),
        .legal_o      (legal),
        .lat_o        (lat),
        .writes_hilo_o(writes_hilo),
        .div_zero_o   (div_zero)
    );

    // Error ops skip the wait entirely; the ALU output is discarded for them anyway.
    assign err_d = !legal || div_zero;
    always_comb begin
        cnt_d = '0;
        if (!err_d) begin
            unique case (lat)
                LAT_MUL: cnt_d = CW'(MUL_CYCLES - 1);
                LAT_DIV: cnt_d = CW'(DIV_CYCLES - 1);
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_z_q     <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            err_q       <= 1'b0;
            hilo_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.req_valid) begin
                    alu_a_q  <= bus.req_a;
                    alu_b_q  <= bus.req_b;
                    alu_op_q <= bus.req_opcode;
                    cnt_q    <= cnt_d;
                    err_q    <= err_d;
                    hilo_q   <= writes_hilo && !err_d;
                    busy_q   <= 1'b1;
                    state_q  <= EXEC;
                end
                EXEC: if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    res_z_q     <= err_q ? 64'd0 : bus.alu_c;
                    res_err_q   <= err_q;
                    res_valid_q <= 1'b1;
                    if (hilo_q) begin
                        hi_q <= bus.alu_c[63:32];
                        lo_q <= bus.alu_c[31:0];
                    end
                    state_q <= DONE;
                end
                DONE: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_z      = res_z_q;
    assign bus.res_err    = res_err_q;
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Random + directed bench for alu_sequencer with a behavioural ALU and transaction-level model.
module tb_alu_sequencer;
    localparam int MULC = 4;
    localparam int DIVC = 8;

    logic clk = 1'b0;
    logic clear = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    alu_sequencer_if bus();
    alu_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (.clk(clk), .clear(clear), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        int          lat;
        logic [63:0] z;
        logic        err;
    } exp_t;

    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [5:0] s;
        s = {1'b0, b[4:0]};
        case (op)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a >> s};
            5'd6:  return {32'd0, a << s};
            5'd7:  return {32'd0, (a >> s) | (a << (6'd32 - s))};
            5'd8:  return {32'd0, (a << s) | (a >> (6'd32 - s))};
            5'd9:  return {32'd0, a & b};
            5'd10: return {32'd0, a | b};
            5'd14: return {32'd0, a} * {32'd0, b};
            5'd15: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
            5'd16: return {32'd0, -a};
            5'd17: return {32'd0, ~a};
            default: return {a ^ 32'hA5A5_5A5A, b};
        endcase
    endfunction

    assign bus.alu_c = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17};
    endfunction

    // Expected outcome of one operation; also advances the HI/LO model.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.acc = 0;
        if (!is_legal(op) || (op == 5'd15 && b == 0)) begin
            e.lat = 1; e.z = 64'd0; e.err = 1'b1;
        end else begin
            e.lat = (op == 5'd14) ? MULC : (op == 5'd15) ? DIVC : 1;
            e.z = alu_fn(op, a, b);
            e.err = 1'b0;
            if (op == 5'd14 || op == 5'd15) begin
                hi_m = e.z[63:32];
                lo_m = e.z[31:0];
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_alu_a"}, {32'd0, bus.alu_a}, 64'd0);
        chk({tag, "_alu_b"}, {32'd0, bus.alu_b}, 64'd0);
        chk({tag, "_alu_op"}, {59'd0, bus.alu_opcode}, 64'd0);
        chk({tag, "_res_z"}, bus.res_z, 64'd0);
        chk({tag, "_res_err"}, {63'd0, bus.res_err}, 64'd0);
        chk({tag, "_res_valid"}, {63'd0, bus.res_valid}, 64'd0);
        chk({tag, "_hi"}, {32'd0, bus.hi_out}, 64'd0);
        chk({tag, "_lo"}, {32'd0, bus.lo_out}, 64'd0);
        chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask

    // One full transaction; hold = cycles res_ready stays low once the result shows up.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int t;
        logic [63:0] z0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_a = a; bus.req_b = b;
        bus.res_ready = (hold == 0);
        t = 0;
        while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin chk("accept_timeout", 64'd0, 64'd1); bus.req_valid = 1'b0; return; end
        e = model(op, a, b);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a = $urandom; bus.req_b = $urandom; bus.req_opcode = 5'($urandom);
        chk("alu_a", {32'd0, bus.alu_a}, {32'd0, a});
        chk("alu_b", {32'd0, bus.alu_b}, {32'd0, b});
        chk("alu_op", {59'd0, bus.alu_opcode}, {59'd0, op});
        chk("busy", {63'd0, bus.busy}, 64'd1);
        t = 0;
        while (!bus.res_valid && t < 50) begin @(posedge clk); #1; t++; end
        chk("latency", 64'(t), 64'(e.lat));
        chk("res_z", bus.res_z, e.z);
        chk("res_err", {63'd0, bus.res_err}, {63'd0, e.err});
        chk("hi", {32'd0, bus.hi_out}, {32'd0, hi_m});
        chk("lo", {32'd0, bus.lo_out}, {32'd0, lo_m});
        z0 = bus.res_z;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, bus.res_valid}, 64'd1);
            chk("hold_z", bus.res_z, z0);
            chk("hold_rdy", {63'd0, bus.req_ready}, 64'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_valid", {63'd0, bus.res_valid}, 64'd0);
        chk("post_rdy", {63'd0, bus.req_ready}, 64'd1);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops [12] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17};
        exp_t q[$];
        exp_t e;
        int prev_acc, prev_lat, t;
        logic [4:0] op;
        logic [31:0] a, b;

        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 1'b0;
        #12;
        chk_zero_outputs("rst");
        @(negedge clk); clear = 1'b1;
        #1 chk("rst_rdy", {63'd0, bus.req_ready}, 64'd1);

        do_op(5'd3, 32'd5, 32'd7, 0);
        do_op(5'd14, 32'h0001_0000, 32'h0001_0000, 0);
        do_op(5'd15, 32'd17, 32'd5, 0);
        do_op(5'd15, 32'd7, 32'd0, 0);
        do_op(5'd0, 32'd9, 32'd9, 3);

        // Reset two cycles into a multiply: abort with everything back to zero.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opcode = 5'd14; bus.req_a = 32'd3; bus.req_b = 32'd4;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        clear = 1'b0;
        #1 chk_zero_outputs("abort");
        hi_m = '0; lo_m = '0;
        @(negedge clk); clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 chk("abort_novalid", {63'd0, bus.res_valid}, 64'd0);
        end
        do_op(5'd3, 32'd1, 32'd1, 0);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 5) == 0) ? 5'($urandom) : ops[$urandom_range(0, 11)];
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            do_op(op, a, b, $urandom_range(0, 2));
        end

        // Streaming: requester keeps valid high and keeps changing operands.
        bus.res_ready = 1'b1;
        prev_acc = -1; prev_lat = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                if (q.size() == 0) chk("stream_spurious", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    chk("stream_lat", 64'(k - e.acc), 64'(e.lat));
                    chk("stream_z", bus.res_z, e.z);
                    chk("stream_err", {63'd0, bus.res_err}, {63'd0, e.err});
                end
            end
            op = ops[$urandom_range(0, 11)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_a = a; bus.req_b = b;
            if (bus.req_ready) begin
                e = model(op, a, b);
                e.acc = k + 1;
                if (prev_acc >= 0) chk("stream_spacing", 64'(e.acc - prev_acc), 64'(prev_lat + 2));
                prev_acc = e.acc; prev_lat = e.lat;
                q.push_back(e);
            end
        end
        bus.req_valid = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 40) begin
            @(negedge clk); t++;
            if (bus.res_valid) begin
                e = q.pop_front();
                chk("drain_z", bus.res_z, e.z);
                chk("drain_err", {63'd0, bus.res_err}, {63'd0, e.err});
            end
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(negedge clk);
        chk("final_hi", {32'd0, bus.hi_out}, {32'd0, hi_m});
        chk("final_lo", {32'd0, bus.lo_out}, {32'd0, lo_m});
        chk("final_idle", {63'd0, bus.busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sits in front of the combinational 32-bit ALU. It accepts one operation at a time over a valid/ready request port, registers the operands and opcode that drive the ALU, and waits a per-class latency. It then captures the 64-bit ALU result, updates the HI/LO registers on multiply and divide, and presents the result on a valid/ready response port.

## Interface
- `MUL_CYCLES`, default 4: cycles allowed for the multiplier to settle (≥1).
- `DIV_CYCLES`, default 8: cycles allowed for the divider to settle (≥1).

- `clk`  in  1  sole clock, rising edge.
- `clear`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_opcode`  in  5  ALU opcode.
- `req_a`, `req_b`  in  32  operands.
- `alu_a`, `alu_b`  out  32  registered operands to ALU.
- `alu_opcode`  out  5  registered opcode to ALU.
- `alu_c`  in  64  ALU result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_z`  out  64  captured result.
- `res_err`  out  1  illegal opcode or divide-by-zero.
- `hi_out`, `lo_out`  out  32  HI/LO registers.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Legal opcodes:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, neg 10000, not 10001: latency L=1.
  - mul 01110: L=MUL_CYCLES.
  - div 01111: L=DIV_CYCLES.
- Any other opcode is illegal.
- States: IDLE, EXEC, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_a`/`req_b`/`req_opcode` into `alu_a`/`alu_b`/`alu_opcode`, load the counter with L−1, go to EXEC.
- Illegal opcode or div with `req_b`==0:
  - Latch operands as normal, load the counter with 0 (L forced to 1).
  - Mark the operation as error.
- EXEC:
  - When the counter is nonzero, decrement it.
  - When the counter is 0, capture the result and go to DONE.
- Capture, normal operation:
  - `res_z` ← `alu_c`.
  - For mul/div only: `hi_out` ← `alu_c[63:32]`, `lo_out` ← `alu_c[31:0]`.
  - `res_err`=0.
- Capture, error operation:
  - `res_z`=0, `res_err`=1.
  - HI/LO unchanged.
- DONE:
  - `res_valid`=1; `res_z` and `res_err` are held stable.
  - On `res_ready`, go to IDLE.
  - `req_ready`=0, so no request is accepted in the same cycle the result is consumed.
- `alu_*` hold the last accepted values between operations. The ALU output is sampled only at capture.
- Divider packing: remainder in `alu_c[63:32]`, quotient in `alu_c[31:0]`.

## Timing
- Reset (`clear`=0, asynchronous):
  - state=IDLE, counter=0.
  - All of these outputs are 0: `alu_a`, `alu_b`, `alu_opcode`, `res_z`, `res_err`, `res_valid`, `hi_out`, `lo_out`, `busy`.
  - `req_ready`=1 once reset is released.
- Reset mid-EXEC or mid-DONE aborts the operation. No capture occurs and HI/LO return to 0.
- Accept edge E0: `alu_*` are valid after E0.
- Result latency:
  - `res_valid` rises after edge E0+L: E0+1 for simple ops, E0+MUL_CYCLES for mul, E0+DIV_CYCLES for div.
  - HI/LO update on the same edge.
- Handshake:
  - `res_valid` stays high until a cycle with `res_ready`=1.
  - The next `req_ready` is high in the following cycle.
  - Minimum spacing between accepts is L+2 cycles.
- `req_valid` seen while not in IDLE is ignored. The requester must hold the request until `req_ready`.
- `res_ready` high outside DONE has no effect.

## Structure
- Shared package `alu_seq_pkg`:
  - 5-bit opcode localparams (names matching the ALU opcode set).
  - State enum {IDLE, EXEC, DONE}.
  - Latency-class enum {LAT_SIMPLE, LAT_MUL, LAT_DIV}.
- Sub-module `alu_op_decode` (combinational):
  - Inputs: opcode, `req_b`.
  - Outputs: `legal`, latency class, `writes_hilo`, `div_zero`.
- Top level holds the FSM, counter, operand registers and result registers.

## Test plan
- Add 5+7 with `res_ready`=1 → `res_valid` one cycle after accept; `res_z`=12, `res_err`=0; HI/LO unchanged.
- Mul 0x0001_0000 × 0x0001_0000 → `res_valid` after edge E0+MUL_CYCLES; `res_z`=0x0000_0001_0000_0000, `hi_out`=1, `lo_out`=0.
- Div 17/5 → `lo_out`=3, `hi_out`=2 after DIV_CYCLES. Then div 7/0 → `res_err`=1, `res_z`=0 after 1 cycle; HI/LO still 2/3.
- Opcode 00000 → `res_err`=1 after 1 cycle. Then `res_ready` held low for 3 cycles → `res_valid`/`res_z` stable and `req_ready`=0 throughout.
- Assert `clear` two cycles into a mul → all outputs 0 immediately, `res_valid` never rises. A new add 1+1 after release → `res_z`=2.
- Assert `req_valid` continuously with changing operands while busy → only the operands present at accept edges are used, at an accept spacing of L+2.
